// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back, write-allocate data cache that sits between the
// CPU MEM stage and off-chip data memory. Single-word CPU loads/stores that hit
// complete in the request cycle. A miss stalls the pipeline while the victim
// line is written back (if dirty) and the requested block is filled. The
// request is then re-evaluated as a hit.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset (clears valid/dirty, FSM -> IDLE)
//   cpu_req_i    MEM-stage load/store valid
//   cpu_we_i     1 = store, 0 = load
//   cpu_addr_i   byte address (bits [1:0] ignored)
//   cpu_data_i   store data
//   cpu_data_o   load data (selected word on a hit, else 0)
//   cpu_stall_o  freezes PC and pipeline buffers
//   mem_req_o    memory transaction enable
//   mem_we_o     1 = block write-back, 0 = block fill
//   mem_addr_o   block-aligned memory address
//   mem_data_o   write-back block (0 outside WRITEBACK)
//   mem_data_i   fill block
//   mem_ack_i    one-cycle completion pulse from memory
// -----------------------------------------------------------------------------
module dcache_controller #(
  parameter int LINES      = 32,
  parameter int BLOCK_BITS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_data_i,
  output logic [31:0]           cpu_data_o,
  output logic                  cpu_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_data_o,
  input  logic [BLOCK_BITS-1:0] mem_data_i,
  input  logic                  mem_ack_i
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
  localparam int WSEL_W = $clog2(BLOCK_BITS / 32);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [BLOCK_BITS-1:0] data_q [LINES];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WSEL_W-1:0]     wsel;
  logic [TAG_W-1:0]      cur_tag;
  logic [BLOCK_BITS-1:0] cur_line;
  logic                  hit;

  logic                  line_we;
  logic                  tag_we;
  logic [BLOCK_BITS-1:0] line_wdata;

  // Byte-within-word bits carry no information for a word-wide cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // The CPU holds the address stable for the whole miss sequence, so the
  // same index/tag fields address the line during write-back and refill.
  assign idx      = cpu_addr_i[OFF_W +: IDX_W];
  assign req_tag  = cpu_addr_i[31 -: TAG_W];
  assign wsel     = cpu_addr_i[2 +: WSEL_W];
  assign cur_tag  = tag_q[idx];
  assign cur_line = data_q[idx];

  assign hit = cpu_req_i & valid_q[idx] & (cur_tag == req_tag);

  // Next-state logic plus line/valid/dirty update requests. Store hits are
  // only honoured in IDLE; in DONE the line already hits but the FSM must
  // first return to IDLE so the store is applied exactly once.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = cur_line;

    case (state_q)
      IDLE: begin
        if (hit && cpu_we_i) begin
          line_we                        = 1'b1;
          line_wdata[32*wsel +: 32]      = cpu_data_i;
          dirty_d[idx]                   = 1'b1;
        end else if (cpu_req_i && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          line_we      = 1'b1;
          tag_we       = 1'b1;
          line_wdata   = mem_data_i;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays are plain storage: validity is tracked separately,
  // so they need no reset. Writes cannot occur while reset is held because
  // the FSM sits in IDLE with every line invalid.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      data_q[idx] <= line_wdata;
    end
    if (tag_we) begin
      tag_q[idx] <= req_tag;
    end
  end

  assign cpu_stall_o = (state_q != IDLE) | (cpu_req_i & ~hit);
  assign cpu_data_o  = hit ? cur_line[32*wsel +: 32] : 32'd0;

  // Memory-side outputs decode straight from the state register, so the
  // request appears the cycle after the miss and stays up across the
  // WRITEBACK -> REFILL handoff with only address/direction changing.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 32'd0;
    mem_data_o = '0;
    case (state_q)
      WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {cur_tag, idx, {OFF_W{1'b0}}};
        mem_data_o = cur_line;
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, idx, {OFF_W{1'b0}}};
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_controller
//
// Scoreboard bench for dcache_controller. Expected load data and expected
// memory transactions are queued as each request is issued; a behavioural
// memory responder pops and compares transactions as the cache starts them,
// and the request task pops load data when the stall drops.
// -----------------------------------------------------------------------------
module tb_dcache_controller;

  localparam int ACK_LAT = 9;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i  = 1'b0;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_txn_t;

  mem_txn_t     exp_mem_q[$];
  logic [31:0]  exp_load_q[$];
  logic [255:0] wb_mem [logic [31:0]];

  int vec_count   = 0;
  int miscompares = 0;
  int cycle       = 0;
  int ack_cycle   = 0;

  bit           busy         = 1'b0;
  bit           resp_en      = 1'b1;
  bit           spurious_ack = 1'b0;
  int           cnt          = 0;
  logic         cur_we       = 1'b0;
  logic [31:0]  cur_addr     = '0;
  logic [255:0] cur_wdata    = '0;

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  // Backing-store contents for a block never written back: word k of block
  // address a is 0x1000 + (a - 0x40) + k, so block 0x40 holds 0x1000+k.
  function automatic logic [255:0] pattern_blk(input logic [31:0] a);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) begin
      b[32*k +: 32] = 32'h1000 + (a - 32'h40) + k;
    end
    return b;
  endfunction

  function automatic logic [255:0] with_word(input logic [255:0] blk, input int w,
                                             input logic [31:0] val);
    logic [255:0] b;
    b = blk;
    b[32*w +: 32] = val;
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expectMem(input logic we, input logic [31:0] addr,
                           input logic [255:0] data);
    mem_txn_t t;
    t.we   = we;
    t.addr = addr;
    t.data = data;
    exp_mem_q.push_back(t);
  endtask

  // Memory responder: on each new transaction compare it with the head of
  // the expected-transaction queue, then ack after ACK_LAT+1 cycles. A
  // request that drops while pending (reset) abandons the transaction.
  always @(negedge clk_i) begin
    mem_txn_t e;
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      busy      = 1'b0;
    end else if (spurious_ack) begin
      spurious_ack = 1'b0;
      mem_ack_i    = 1'b1;
    end
    if (busy && !mem_req_o) busy = 1'b0;
    if (resp_en && !busy && mem_req_o) begin
      busy      = 1'b1;
      cnt       = ACK_LAT;
      cur_we    = mem_we_o;
      cur_addr  = mem_addr_o;
      cur_wdata = mem_data_o;
      if (exp_mem_q.size() == 0) begin
        checkOutput("unexpected_mem_req", mem_req_o, 1'b0);
      end else begin
        e = exp_mem_q.pop_front();
        checkOutput("mem_we", mem_we_o, e.we);
        checkOutput("mem_addr", mem_addr_o, e.addr);
        if (e.we) checkOutput("mem_wb_data", mem_data_o, e.data);
        else      checkOutput("mem_data_zero_in_fill", mem_data_o, '0);
      end
    end else if (busy) begin
      if (cnt == 0) begin
        mem_ack_i = 1'b1;
        ack_cycle = cycle;
        if (cur_we) wb_mem[cur_addr] = cur_wdata;
        else if (wb_mem.exists(cur_addr)) mem_data_i = wb_mem[cur_addr];
        else mem_data_i = pattern_blk(cur_addr);
      end else begin
        cnt--;
      end
    end
  end

  // Issue one CPU request and follow it to completion. Hits must not stall;
  // misses must raise mem_req the next cycle and release the stall exactly
  // two cycles after the final (fill) ack.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit exp_hit,
                               input logic [31:0] exp_rdata);
    int n;
    logic [31:0] e;
    if (!we) exp_load_q.push_back(exp_rdata);
    @(posedge clk_i); #1;
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    @(negedge clk_i);
    checkOutput("stall_in_req_cycle", cpu_stall_o, !exp_hit);
    if (exp_hit) begin
      checkOutput("hit_no_mem_req", mem_req_o, 1'b0);
    end else begin
      @(negedge clk_i);
      checkOutput("mem_req_next_cycle", mem_req_o, 1'b1);
      n = 0;
      while (cpu_stall_o && n < 400) begin
        @(negedge clk_i);
        n++;
      end
      if (cpu_stall_o) checkOutput("stall_timeout", cpu_stall_o, 1'b0);
      else             checkOutput("stall_fall_after_ack", cycle - ack_cycle, 2);
    end
    if (!we) begin
      e = exp_load_q.pop_front();
      checkOutput("load_data", cpu_data_o, e);
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] blk;
    rst_i      = 1'b1;
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;

    // Reset state
    @(negedge clk_i);
    checkOutput("rst_mem_req", mem_req_o, 1'b0);
    checkOutput("rst_mem_we", mem_we_o, 1'b0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
    checkOutput("rst_mem_data", mem_data_o, '0);
    checkOutput("rst_stall", cpu_stall_o, 1'b0);
    checkOutput("rst_cpu_data", cpu_data_o, 32'd0);
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h40;
    #1;
    checkOutput("rst_stall_with_req", cpu_stall_o, 1'b1);
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // 1: clean load miss to 0x40
    expectMem(1'b0, 32'h40, '0);
    applyStimulus(1'b0, 32'h40, 32'd0, 1'b0, 32'h1000);

    // 2: hits on the filled line, store marks it dirty
    applyStimulus(1'b0, 32'h4C, 32'd0, 1'b1, 32'h1003);
    applyStimulus(1'b1, 32'h44, 32'hDEADBEEF, 1'b1, 32'd0);
    applyStimulus(1'b0, 32'h44, 32'd0, 1'b1, 32'hDEADBEEF);

    // 3: conflict miss evicts dirty line 2 then fills 0x440
    expectMem(1'b1, 32'h40, with_word(pattern_blk(32'h40), 1, 32'hDEADBEEF));
    expectMem(1'b0, 32'h440, '0);
    applyStimulus(1'b0, 32'h440, 32'd0, 1'b0, 32'h1400);

    // 4: store miss to clean victim, then its eviction writes it back
    expectMem(1'b0, 32'h880, '0);
    applyStimulus(1'b1, 32'h880, 32'h12345678, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h880, 32'd0, 1'b1, 32'h12345678);
    expectMem(1'b1, 32'h880, with_word(pattern_blk(32'h880), 0, 32'h12345678));
    expectMem(1'b0, 32'h1080, '0);
    applyStimulus(1'b0, 32'h1080, 32'd0, 1'b0, 32'h2040);

    // 5: reset in the middle of a write-back
    applyStimulus(1'b1, 32'h444, 32'hCAFEF00D, 1'b1, 32'd0);
    resp_en = 1'b0;
    @(posedge clk_i); #1;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h40;
    @(negedge clk_i);
    checkOutput("dirty_miss_stall", cpu_stall_o, 1'b1);
    @(negedge clk_i);
    checkOutput("wb_req", mem_req_o, 1'b1);
    checkOutput("wb_we", mem_we_o, 1'b1);
    checkOutput("wb_addr", mem_addr_o, 32'h440);
    blk = with_word(pattern_blk(32'h440), 1, 32'hCAFEF00D);
    checkOutput("wb_data", mem_data_o, blk);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_mem_req", mem_req_o, 1'b0);
    checkOutput("midrst_mem_we", mem_we_o, 1'b0);
    checkOutput("midrst_mem_addr", mem_addr_o, 32'd0);
    checkOutput("midrst_mem_data", mem_data_o, '0);
    cpu_req_i = 1'b0;
    #1;
    checkOutput("midrst_stall", cpu_stall_o, 1'b0);
    checkOutput("midrst_cpu_data", cpu_data_o, 32'd0);
    @(negedge clk_i);
    rst_i   = 1'b0;
    resp_en = 1'b1;

    // Spurious ack while idle must not start anything
    spurious_ack = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("spurious_ack_mem_req", mem_req_o, 1'b0);
    checkOutput("spurious_ack_stall", cpu_stall_o, 1'b0);

    // Line 2 was invalidated: clean fill, dirty store data lost
    expectMem(1'b0, 32'h440, '0);
    applyStimulus(1'b0, 32'h440, 32'd0, 1'b0, 32'h1400);
    applyStimulus(1'b0, 32'h444, 32'd0, 1'b1, 32'h1401);

    repeat (2) @(negedge clk_i);
    checkOutput("mem_txns_outstanding", exp_mem_q.size(), 0);
    checkOutput("loads_outstanding", exp_load_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and the off-chip data memory. It turns the MEM stage's single-word load/store requests into 256-bit block transfers. It raises a stall to freeze the pipeline on a miss. Hits complete in the request cycle with no stall.

## Interface
Parameters:
- LINES, 32, number of cache lines; the index is log2(LINES) bits wide.
- BLOCK_BITS, 256, line size in bits (8 words).

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous active-high reset.
- cpu_req_i  input  1  MEM-stage load/store valid.
- cpu_we_i  input  1  1 = store, 0 = load.
- cpu_addr_i  input  32  byte address; bits [1:0] are ignored.
- cpu_data_i  input  32  store data.
- cpu_data_o  output  32  load data; valid when cpu_req_i=1, cpu_we_i=0 and cpu_stall_o=0.
- cpu_stall_o  output  1  freezes the PC and all pipeline buffers.
- mem_req_o  output  1  memory transaction enable.
- mem_we_o  output  1  1 = block write-back, 0 = block fill.
- mem_addr_o  output  32  block-aligned address; bits [4:0] are 0.
- mem_data_o  output  256  write-back block.
- mem_data_i  input  256  fill block.
- mem_ack_i  input  1  one-cycle completion pulse from memory.

## Operation
- Address split: offset [4:0], word select [4:2], index [9:5], tag [31:10] (22 bits).
- Per-line storage: valid bit, dirty bit, tag, 256-bit data. Word w occupies data bits [32w+31:32w].
- Hit = cpu_req_i & valid[index] & (tag[index] == addr tag). Hit detection is combinational.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
- IDLE, no request: no action.
- IDLE, load hit: cpu_data_o returns the selected word combinationally. No stall.
- IDLE, store hit: the selected word is replaced by cpu_data_i at the clock edge and dirty is set. No stall.
- IDLE, miss: cpu_stall_o=1 combinationally in the same cycle.
  - If the victim line is valid and dirty, next state is WRITEBACK.
  - Otherwise next state is REFILL.
- WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o = victim block. On mem_ack_i, next state is REFILL.
- REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o={request tag, index, 5'b0}. On mem_ack_i the line takes data mem_data_i, tag = request tag, valid=1, dirty=0. Next state is DONE.
- DONE: stall held. Next state is IDLE, where the request is re-evaluated and hits. A store miss therefore completes as a store hit after the fill.
- cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit).
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1. Inputs that change while stalled have undefined results.
- mem_ack_i is ignored in IDLE and DONE.
- mem_data_o is driven only in WRITEBACK; it is 0 otherwise.
- Reset (asynchronous, any state):
  - state=IDLE.
  - Every valid and dirty bit cleared. Data and tag arrays are not cleared.
  - mem_req_o, mem_we_o, mem_addr_o, mem_data_o all 0.
  - cpu_stall_o=0 unless a request is presented.
  - cpu_data_o=0 when there is no hit.
- Reset mid-transaction drops the transaction immediately. No partial line is kept, and dirty data is lost.

## Timing
- Hit: zero wait cycles. Load data and store update occur in the request cycle.
- Miss is detected in cycle T. mem_req_o is registered and first high at T+1.
- mem_req_o stays high up to and including the ack cycle. For a write-back it drops for no cycle between WRITEBACK and REFILL; mem_we_o and mem_addr_o switch at the ack edge.
- Clean miss with fill ack at cycle A: line written at the A edge, DONE at A+1, IDLE/hit at A+2. cpu_stall_o falls at A+2, and load data is valid in that cycle.
- Dirty miss: write-back ack at cycle B; REFILL from B+1. Then the same sequence as a clean miss.
- Back-to-back misses to different lines each incur the full sequence. No request pipelining.

## Test plan
1. Reset, then load 0x0000_0040. Expected: stall high in the same cycle; mem_req_o=1, mem_we_o=0, mem_addr_o=0x40 from the next cycle. Ack after 10 cycles with word k = 0x1000+k. Then stall falls 2 cycles after ack and cpu_data_o=0x1000.
2. Load 0x0000_004C, then store 0x0000_0044 = 0xDEADBEEF, then load 0x44. Expected: no stall on any of the three; data is 0x1003, then 0xDEADBEEF; mem_req_o stays 0.
3. Load 0x0000_0440 (same index 2, tag 1). Expected: write-back at mem_addr_o=0x40 with mem_data_o word1 = 0xDEADBEEF and other words 0x1000+k. After that ack, a fill at 0x440. The final load returns fill word 0.
4. Store miss to 0x0000_0880 = 0x12345678. Expected: clean-victim path goes straight to fill without write-back. Next load 0x880 returns 0x12345678. A later eviction writes that line back.
5. Assert rst_i during WRITEBACK, before ack. Expected: mem_req_o=0 immediately. Afterwards a load of 0x440 misses and fills with no write-back. Spurious mem_ack_i pulses in IDLE change no state.
